dmem_bus_responder: RTL and testbench

//  Data-memory responder for the core's load/store port (core = initiator, this block = responder).

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_sram_array.sv | 38 +++
 rtl/dmem_bus_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_bus_responder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its RAM.
package dmem_pkg;

  localparam int unsigned WSTRB_W     = 4;
  localparam int unsigned WORD_OFFSET = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2
  } err_cause_t;

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port word RAM: synchronous read, per-byte strobed write.
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic               i_we,
  input  logic [AW-1:0]      i_idx,
  input  logic [DATA_W-1:0]  i_wdata,
  input  logic [WSTRB_W-1:0] i_wstrb,
  output logic [DATA_W-1:0]  o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      for (int b = 0; b < int'(WSTRB_W); b++) begin
        if (i_wstrb[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_rdata <= '0;
    else if (i_en && !i_we)  r_rdata <= r_mem[i_idx];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_bus_responder.sv
// Load/store responder: one request at a time, LATENCY wait cycles, word access,
// registered response held until the initiator takes it.
module dmem_bus_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  input  logic [WSTRB_W-1:0] req_wstrb,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               rsp_err
);

  localparam int unsigned IDX_W = ADDR_W - WORD_OFFSET;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [WSTRB_W-1:0] r_wstrb;
  logic               r_acc_err;
  logic               r_req_ready, r_rsp_valid, r_rsp_err;
  logic [DATA_W-1:0]  r_rsp_rdata;

  logic               w_accept, w_rsp_done, w_err, w_ram_en, w_ram_we;
  logic [IDX_W-1:0]   w_idx;
  logic [DATA_W-1:0]  w_ram_rdata;
  err_cause_t         w_cause;

  assign w_accept   = (r_state == ST_IDLE) && req_valid && r_req_ready;
  assign w_rsp_done = (r_state == ST_RESP) && r_rsp_valid && rsp_ready;
  assign w_idx      = r_addr[ADDR_W-1:WORD_OFFSET];

  // Misalignment takes precedence over range when both apply.
  always_comb begin
    w_cause = ERR_NONE;
    if (r_addr[WORD_OFFSET-1:0] != '0)      w_cause = ERR_MISALIGN;
    else if (w_idx >= IDX_W'(DEPTH))        w_cause = ERR_RANGE;
  end
  assign w_err = (w_cause != ERR_NONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = (LATENCY > 0) ? ST_WAIT : ST_ACCESS;
      ST_WAIT:   if (r_cnt == '0) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   if (w_rsp_done) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // The RAM is touched only in ACCESS, and never for a faulting address.
  always_comb begin
    w_ram_en = 1'b0;
    w_ram_we = 1'b0;
    if (r_state == ST_ACCESS) begin
      w_ram_en = !w_err;
      w_ram_we = r_we;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_acc_err   <= 1'b0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == ST_IDLE);
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_we    <= req_we;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_wstrb <= req_wstrb;
          r_cnt   <= CNT_INIT;
        end
        ST_WAIT:   if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        ST_ACCESS: r_acc_err <= w_err;
        ST_RESP: begin
          // First RESP cycle picks up the RAM read; afterwards hold until taken.
          if (!r_rsp_valid) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= (r_we || r_acc_err) ? '0 : w_ram_rdata;
            r_rsp_err   <= r_acc_err;
          end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  dmem_sram_array #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_sram (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_idx   (w_idx[AW-1:0]),
    .i_wdata (r_wdata),
    .i_wstrb (r_wstrb),
    .o_rdata (w_ram_rdata)
  );

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Scoreboard bench for dmem_bus_responder: directed loads/stores, errors, backpressure, reset abort.
module tb_dmem_bus_responder;
  localparam int unsigned LATENCY = 2;
  localparam int unsigned DEPTH   = 1024;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  dmem_bus_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b with nothing expected", rsp_rdata, rsp_err);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  // Present one request, wait for acceptance, then for rsp_valid; returns cycles after acceptance.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] exp_rdata, input logic exp_err,
                       output int lat);
    int n;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) begin checks++; failures++; $display("FAIL accept_timeout: req_ready stuck 0"); end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (lat >= 100) begin checks++; failures++; $display("FAIL rsp_timeout: rsp_valid never rose"); end
  endtask

  // Complete the response handshake (rsp_ready must already be high) and check the return to idle.
  task automatic finish_rsp();
    @(posedge clk); #1;
    chk("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
    chk("req_ready_after_hs", 32'(req_ready), 32'd1);
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    issue(we, addr, wdata, wstrb, exp_rdata, exp_err, lat);
    finish_rsp();
  endtask

  initial begin
    int lat;
    // Reset and idle
    #12;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    #8 rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_req_ready", 32'(req_ready), 32'd1);

    // Full store then load, with latency measured on the store
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, lat);
    chk("store_latency", 32'(lat), 32'(2 + LATENCY));
    chk("req_ready_in_resp", 32'(req_ready), 32'd0);
    finish_rsp();
    issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, lat);
    chk("load_latency", 32'(lat), 32'(2 + LATENCY));
    finish_rsp();

    // Partial store merges one byte
    xfer(1'b1, 32'h14, 32'h11223344, 4'hF, 32'h0, 1'b0);
    xfer(1'b1, 32'h14, 32'h0000AB00, 4'h2, 32'h0, 1'b0);
    xfer(1'b0, 32'h14, 32'h0, 4'h0, 32'h1122AB44, 1'b0);

    // Errors, zero-strobe no-op, and the last legal word
    xfer(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
    xfer(1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer(1'b1, 32'h2, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    xfer(1'b1, 32'(DEPTH * 4), 32'h12345678, 4'hF, 32'h0, 1'b1);
    xfer(1'b0, 32'(DEPTH * 4), 32'h0, 4'h0, 32'h0, 1'b1);
    xfer(1'b1, 32'h0, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    xfer(1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);
    xfer(1'b1, 32'(DEPTH * 4 - 4), 32'hA5A5_0F0F, 4'hF, 32'h0, 1'b0);
    xfer(1'b0, 32'(DEPTH * 4 - 4), 32'h0, 4'h0, 32'hA5A5_0F0F, 1'b0);

    // Backpressure: response held, competing request ignored
    rsp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, lat);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_wstrb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      chk("bp_rsp_err", 32'(rsp_err), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    finish_rsp();
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Reset during WAIT abandons the store
    xfer(1'b1, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55AA55AA; req_wstrb = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
